// File: rtl/rv32i_single_cycle_core.sv
// rv32i_single_cycle_core: single-cycle RV32I core with combinational fetch and byte-enabled data port
module rv32i_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] RF [32];
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < 32; i++) RF[i] <= '0;
    else if (we && wa != 5'd0) RF[wa] <= wd;
  assign rd1 = (ra1 == 5'd0) ? '0 : RF[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : RF[ra2];
endmodule

module rv32i_single_cycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  output logic [31:0] daddr,
  input  logic [31:0] drdata,
  output logic [31:0] dwdata,
  output logic [3:0]  dwe
);
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_R = 7'b0110011;
  logic [31:0] pc, pc4, next_pc, rs1v, rs2v, wd, alu_b, alu_y, sra_y, ld_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  op, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [15:0] lhalf;
  logic [7:0]  lbyte;
  logic        we, st, taken, legal_r, legal_imm;
  assign {f7, rs2, rs1, f3, rd, op} = idata;
  assign imm_i = {{20{idata[31]}}, idata[31:20]};
  assign imm_s = {{20{idata[31]}}, idata[31:25], idata[11:7]};
  assign imm_b = {{19{idata[31]}}, idata[31], idata[7], idata[30:25], idata[11:8], 1'b0};
  assign imm_u = {idata[31:12], 12'b0};
  assign imm_j = {{11{idata[31]}}, idata[31], idata[19:12], idata[20], idata[30:21], 1'b0};
  rv32i_regfile ureg (
    .clk(clk), .reset(reset), .ra1(rs1), .ra2(rs2), .wa(rd), .we(we), .wd(wd),
    .rd1(rs1v), .rd2(rs2v)
  );
  // funct7 only distinguishes SUB/SRA(I); any other pattern is illegal and retires as a NOP
  assign legal_r   = f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5));
  assign legal_imm = f3 == 3'd1 ? f7 == 7'b0 : f3 == 3'd5 ? (f7 == 7'b0 || f7 == 7'b0100000) : 1'b1;
  assign alu_b = (op == OP_R) ? rs2v : imm_i;
  assign sra_y = $signed(rs1v) >>> alu_b[4:0];
  always_comb
    case (f3)
      3'd0:    alu_y = (op == OP_R && f7[5]) ? rs1v - alu_b : rs1v + alu_b;
      3'd1:    alu_y = rs1v << alu_b[4:0];
      3'd2:    alu_y = {31'b0, $signed(rs1v) < $signed(alu_b)};
      3'd3:    alu_y = {31'b0, rs1v < alu_b};
      3'd4:    alu_y = rs1v ^ alu_b;
      3'd5:    alu_y = f7[5] ? sra_y : rs1v >> alu_b[4:0];
      3'd6:    alu_y = rs1v | alu_b;
      default: alu_y = rs1v & alu_b;
    endcase
  assign taken = (f3[2] ? (f3[1] ? rs1v < rs2v : $signed(rs1v) < $signed(rs2v)) : rs1v == rs2v) ^ f3[0];
  assign daddr = rs1v + (op == OP_STORE ? imm_s : imm_i);
  assign lbyte = drdata[{daddr[1:0], 3'b000} +: 8];
  assign lhalf = daddr[1] ? drdata[31:16] : drdata[15:0];
  assign ld_val = f3[1] ? drdata : f3[0] ? {{16{~f3[2] & lhalf[15]}}, lhalf}
                                         : {{24{~f3[2] & lbyte[7]}}, lbyte};
  assign pc4 = pc + 32'd4;
  always_comb begin
    we = 1'b0;
    wd = alu_y;
    st = 1'b0;
    next_pc = pc4;
    case (op)
      OP_LUI:   begin we = 1'b1; wd = imm_u; end
      OP_AUIPC: begin we = 1'b1; wd = pc + imm_u; end
      OP_JAL:   begin we = 1'b1; wd = pc4; next_pc = pc + imm_j; end
      OP_JALR:  if (f3 == 3'd0) begin we = 1'b1; wd = pc4; next_pc = (rs1v + imm_i) & ~32'd1; end
      OP_BR:    if (f3[2:1] != 2'b01 && taken) next_pc = pc + imm_b;
      OP_LOAD:  if (f3 != 3'd3 && f3[2:1] != 2'b11) begin we = 1'b1; wd = ld_val; end
      OP_STORE: st = f3 < 3'd3;
      OP_IMM:   we = legal_imm;
      OP_R:     we = legal_r;
      default:  ;
    endcase
  end
  assign dwe = (st && reset) ? (f3[1] ? 4'b1111 : f3[0] ? (daddr[1] ? 4'b1100 : 4'b0011)
                                                        : 4'b0001 << daddr[1:0]) : 4'b0000;
  assign dwdata = f3[1] ? rs2v : f3[0] ? {2{rs2v[15:0]}} : {4{rs2v[7:0]}};
  assign iaddr = pc;
  always_ff @(posedge clk or negedge reset)
    if (!reset) pc <= RESET_PC;
    else pc <= next_pc;
endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// tb_rv32i_single_cycle_core: directed programs with register and data-bus scoreboards
module tb_rv32i_single_cycle_core;
  logic clk = 1'b0, reset = 1'b0;
  logic [31:0] iaddr, idata, daddr, drdata, dwdata;
  logic [3:0] dwe;
  logic [31:0] rom [256];
  logic [31:0] ram [256];
  logic [31:0] exp_rf [32];
  int vectors = 0, miscompares = 0;
  typedef struct { string tag; int idx; logic [31:0] val; } reg_exp_t;
  typedef struct { string tag; logic [31:0] pc; logic [3:0] dwe; logic [31:0] daddr; logic [31:0] wdata; bit is_st; } bus_exp_t;
  reg_exp_t rq[$];
  bus_exp_t bq[$];

  rv32i_single_cycle_core #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .iaddr(iaddr), .idata(idata), .daddr(daddr),
    .drdata(drdata), .dwdata(dwdata), .dwe(dwe)
  );

  always #5 clk = ~clk;
  assign idata = rom[iaddr[9:2]];
  assign drdata = ram[daddr[9:2]];
  always @(posedge clk)
    for (int b = 0; b < 4; b++) if (dwe[b]) ram[daddr[9:2]][8*b +: 8] <= dwdata[8*b +: 8];

  function automatic logic [31:0] r_t(logic [6:0] f7, logic [2:0] f3, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] i_t(logic [6:0] op, logic [4:0] rd, logic [2:0] f3, logic [4:0] rs1, logic [31:0] imm);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] addi(logic [4:0] rd, logic [4:0] rs1, logic [31:0] imm);
    return i_t(7'h13, rd, 3'd0, rs1, imm);
  endfunction
  function automatic logic [31:0] s_t(logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2, logic [31:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_t(logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2, logic [31:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] u_t(logic [6:0] op, logic [4:0] rd, logic [19:0] imm);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] j_t(logic [4:0] rd, logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_rf(input string tag);
    for (int i = 0; i < 32; i++) begin
      rq.push_back('{tag, i, exp_rf[i]});
      exp_rf[i] = '0;
    end
  endtask

  task automatic drain_regs;
    reg_exp_t e;
    while (rq.size() > 0) begin
      e = rq.pop_front();
      chk($sformatf("%s x%0d", e.tag, e.idx), dut.ureg.RF[e.idx], e.val);
    end
  endtask

  // One instruction retires per iteration; bus expectations are matched by PC in visit order.
  task automatic run(input int n);
    bus_exp_t e;
    repeat (n) begin
      if (bq.size() > 0 && iaddr == bq[0].pc) begin
        e = bq.pop_front();
        chk({e.tag, " dwe"}, 32'(dwe), 32'(e.dwe));
        if (e.is_st) begin
          chk({e.tag, " daddr"}, daddr, e.daddr);
          chk({e.tag, " dwdata"}, dwdata, e.wdata);
        end
      end
      @(negedge clk);
    end
    chk("bus scoreboard drained", bq.size(), 0);
    bq.delete();
  endtask

  task automatic clr_rom;
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset iaddr", iaddr, 32'h0);
    chk("reset dwe", 32'(dwe), 32'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic load_rtype;
    clr_rom;
    rom[0] = addi(1, 0, 5);
    rom[1] = addi(2, 0, -3);
    rom[2] = r_t(7'h00, 3'd0, 3, 1, 2);
    rom[3] = r_t(7'h20, 3'd0, 4, 1, 2);
    rom[4] = r_t(7'h00, 3'd2, 5, 2, 1);
    rom[5] = r_t(7'h00, 3'd3, 6, 2, 1);
    rom[6] = r_t(7'h20, 3'd5, 7, 2, 1);
    rom[7] = r_t(7'h00, 3'd5, 8, 2, 1);
    exp_rf[1] = 32'd5;        exp_rf[2] = 32'hFFFF_FFFD; exp_rf[3] = 32'd2;
    exp_rf[4] = 32'd8;        exp_rf[5] = 32'd1;         exp_rf[6] = 32'd0;
    exp_rf[7] = 32'hFFFF_FFFF; exp_rf[8] = 32'h07FF_FFFF;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) exp_rf[i] = '0;
    // R-type arithmetic, compares and shifts
    load_rtype;
    do_reset;
    push_rf("rtype");
    run(16);
    drain_regs;
    // Logic ops, shift by 31, SLTIU, LUI/AUIPC, x0 write discard, NOP fall-through
    clr_rom;
    rom[0]  = addi(1, 0, 32'h0F0);
    rom[1]  = addi(2, 0, 32'h0FF);
    rom[2]  = r_t(7'h00, 3'd7, 3, 1, 2);
    rom[3]  = r_t(7'h00, 3'd6, 4, 1, 2);
    rom[4]  = r_t(7'h00, 3'd4, 5, 1, 2);
    rom[5]  = r_t(7'h00, 3'd1, 6, 1, 2);
    rom[6]  = i_t(7'h13, 7, 3'd3, 0, -1);
    rom[7]  = u_t(7'h37, 9, 20'h12345);
    rom[8]  = u_t(7'h17, 10, 20'h00001);
    rom[9]  = addi(1, 0, 5);
    rom[10] = r_t(7'h00, 3'd0, 0, 1, 1);
    exp_rf[1] = 32'd5;  exp_rf[2] = 32'hFF;  exp_rf[3] = 32'hF0; exp_rf[4] = 32'hFF;
    exp_rf[5] = 32'h0F; exp_rf[7] = 32'd1;   exp_rf[9] = 32'h1234_5000; exp_rf[10] = 32'h0000_1020;
    do_reset;
    push_rf("logic");
    bq.push_back('{"and no store", 32'd8, 4'b0000, 32'h0, 32'h0, 1'b0});
    run(16);
    chk("nop fall-through pc", iaddr, 32'd64);
    drain_regs;
    // Loads and stores with lane selection and sign/zero extension
    clr_rom;
    rom[0]  = u_t(7'h37, 1, 20'h12345);
    rom[1]  = addi(1, 1, 32'h678);
    rom[2]  = addi(2, 0, 32'hAB);
    rom[3]  = s_t(3'd2, 0, 1, 0);
    rom[4]  = s_t(3'd0, 0, 2, 1);
    rom[5]  = i_t(7'h03, 3, 3'd2, 0, 0);
    rom[6]  = i_t(7'h03, 4, 3'd0, 0, 1);
    rom[7]  = i_t(7'h03, 5, 3'd4, 0, 1);
    rom[8]  = i_t(7'h03, 6, 3'd1, 0, 2);
    rom[9]  = s_t(3'd1, 0, 1, 2);
    rom[10] = i_t(7'h03, 7, 3'd2, 0, 0);
    exp_rf[1] = 32'h1234_5678; exp_rf[2] = 32'hAB;      exp_rf[3] = 32'h1234_AB78;
    exp_rf[4] = 32'hFFFF_FFAB; exp_rf[5] = 32'hAB;      exp_rf[6] = 32'h1234;
    exp_rf[7] = 32'h5678_AB78;
    do_reset;
    push_rf("mem");
    bq.push_back('{"sw", 32'd12, 4'b1111, 32'd0, 32'h1234_5678, 1'b1});
    bq.push_back('{"sb", 32'd16, 4'b0010, 32'd1, 32'hABAB_ABAB, 1'b1});
    bq.push_back('{"lw", 32'd20, 4'b0000, 32'd0, 32'h0, 1'b0});
    bq.push_back('{"sh", 32'd36, 4'b1100, 32'd2, 32'h5678_5678, 1'b1});
    run(16);
    drain_regs;
    // Branches, JAL call, JALR return
    clr_rom;
    rom[0]  = b_t(3'd0, 0, 0, 8);
    rom[1]  = addi(5, 0, 7);
    rom[2]  = j_t(1, 12);
    rom[3]  = addi(6, 0, 9);
    rom[4]  = j_t(0, 12);
    rom[5]  = addi(7, 0, 3);
    rom[6]  = i_t(7'h67, 0, 3'd0, 1, 0);
    rom[7]  = b_t(3'd1, 0, 0, 8);
    rom[8]  = addi(8, 0, 1);
    rom[9]  = addi(2, 0, -1);
    rom[10] = b_t(3'd6, 0, 2, 8);
    rom[11] = addi(9, 0, 1);
    rom[12] = b_t(3'd5, 2, 0, 8);
    rom[13] = addi(10, 0, 1);
    exp_rf[1] = 32'd12; exp_rf[2] = 32'hFFFF_FFFF; exp_rf[6] = 32'd9;
    exp_rf[7] = 32'd3;  exp_rf[8] = 32'd1;         exp_rf[10] = 32'd1;
    do_reset;
    push_rf("ctrl");
    bq.push_back('{"jalr no store", 32'd24, 4'b0000, 32'h0, 32'h0, 1'b0});
    run(20);
    chk("ctrl final pc", iaddr, 32'd88);
    drain_regs;
    // Asynchronous reset mid-program, then restart from address 0
    load_rtype;
    do_reset;
    run(10);
    #1 reset = 1'b0;
    #1;
    chk("async reset iaddr", iaddr, 32'h0);
    chk("async reset dwe", 32'(dwe), 32'h0);
    for (int i = 0; i < 32; i++) rq.push_back('{"async reset", i, 32'h0});
    drain_regs;
    @(negedge clk);
    reset = 1'b1;
    chk("restart iaddr", iaddr, 32'h0);
    load_rtype;
    push_rf("restart");
    run(16);
    drain_regs;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
